sm_bus_snoop: RTL and testbench
===============================

// Module: sm_bus_snoop
// PURPOSE
//  Bus-side (snoop) half of the per-core MSI coherence controller; consumes bus messages
//  (readMiss/writeMiss/invalidate) issued by other cores' sm_cpu instances.
//  Owns the core's line-state/tag table; the local CPU-side FSM writes its next state through the update port.
//  Demotes or invalidates hit lines; on a Modified hit, performs a write-back handshake and aborts the memory access.
// PARAMETERS
//  NUM_LINES  4  direct-mapped lines tracked (power of 2)
//  IDX_W      2  line index width, clog2(NUM_LINES)
//  TAG_W      8  tag width
// PORTS
//  clock          in   1      rising-edge clock
//  reset          in   1      synchronous, active-high
//  snoop_valid    in   1      bus message present
//  snoop_ready    out  1      message accepted when valid&ready
//  snoop_op       in   2      01 readMiss, 10 writeMiss, 11 invalidate, 00 ignored (accepted, no effect)
//  snoop_index    in   IDX_W  line index of bus address
//  snoop_tag      in   TAG_W  tag of bus address
//  cpu_upd_valid  in   1      local CPU FSM writes table entry
//  cpu_upd_ready  out  1      update accepted when valid&ready
//  cpu_upd_index  in   IDX_W  entry index
//  cpu_upd_tag    in   TAG_W  new tag
//  cpu_upd_state  in   2      new state: 00 Invalid, 01 Shared, 10 Modified (11 ignored, entry unchanged)
//  line_state     out  2      state of entry cpu_upd_index (combinational read, for sm_cpu's currentState)
//  wb_valid       out  1      write-back request to memory
//  wb_ready       in   1      memory accepts write-back
//  wb_index/wb_tag out IDX_W/TAG_W  line being written back
//  abort_mem      out  1      one-cycle pulse: memory must not answer this bus miss (this core supplies data)
//  snoop_done     out  1      one-cycle pulse: message fully processed
// BEHAVIOUR
//  Reset: all entries Invalid, tags 0; FSM IDLE; snoop_ready=1, wb_valid=0, abort_mem=0, snoop_done=0.
//  FSM: IDLE -> LOOKUP -> (WB) -> IDLE.
//   IDLE: snoop_ready=1; on snoop_valid, register op/index/tag and go to LOOKUP.
//   LOOKUP (1 cycle): hit = entry.state!=Invalid && entry.tag==tag_q.
//    miss, or op 00 -> snoop_done, IDLE
//    Shared + readMiss -> no change; snoop_done, IDLE
//    Shared + writeMiss/invalidate -> Invalid; snoop_done, IDLE
//    Modified + readMiss -> Shared; abort_mem pulse; go to WB
//    Modified + writeMiss -> Invalid; abort_mem pulse; go to WB
//    Modified + invalidate -> protocol error; treat as writeMiss
//   WB: wb_valid=1 with wb_index/wb_tag held stable until wb_ready; on the handshake cycle, snoop_done and IDLE.
//  Latency: non-WB message 2 cycles accept->done; WB adds >=1 cycle (wb_ready held high = 3).
//  State write happens at the end of the LOOKUP cycle; wb_valid asserts the following cycle.
//  CPU update: cpu_upd_ready=0 only when FSM!=IDLE and cpu_upd_index==index_q, else 1.
//   In the IDLE accept cycle the CPU write lands first; LOOKUP sees the new value.
//  Only one table write per cycle: in LOOKUP the snoop write owns index_q; CPU writes to other indices proceed in parallel.
//  line_state is combinational from the table; it reflects snoop changes the cycle after LOOKUP.
//  Reset mid-transaction: FSM to IDLE, wb_valid drops immediately, table cleared; the pending write-back is lost.
// STRUCTURE
//  Shared package: MSI state constants (INVALID=2'b00, SHARED=2'b01, MODIFIED=2'b10),
//   bus opcode constants (OP_RDMISS/OP_WRMISS/OP_INV), used by sm_cpu as well.
//  One sub-module: line_table (NUM_LINES x {TAG_W,2}, two async read ports, one write port with the arbitration above).
//  Top: snoop FSM, write-back handshake, update-port ready logic.
// TESTING
//  1. Reset, CPU update idx1 tag 0x3A Modified; snoop readMiss idx1 tag 0x3A, wb_ready=1
//     -> abort_mem pulse, wb_valid 1 cycle with idx1/0x3A, line_state=01, snoop_done at cycle 3.
//  2. idx2 Shared tag 0x10; snoop invalidate idx2 tag 0x10 -> line_state=00 after 2 cycles,
//     no wb_valid, no abort.
//  3. idx0 Modified tag 0x05; snoop writeMiss idx0 tag 0x06 (tag mismatch) -> no change, snoop_done at cycle 2.
//  4. idx3 Modified; writeMiss hit, wb_ready low 4 cycles -> wb_valid/wb_tag stable,
//     snoop_ready=0 and CPU update to idx3 stalled throughout; CPU update to idx0 accepted; entry Invalid.
//  5. Same-cycle CPU update idx1->Modified tag 0x22 with snoop readMiss idx1 tag 0x22 accepted
//     -> LOOKUP hits Modified, write-back issued, final state Shared.
//  6. Assert reset during WB wait -> next cycle wb_valid=0, snoop_ready=1, all line_state=00.

Source files
------------

// File: rtl/sm_bus_snoop_pkg.sv
// Shared MSI coherence definitions: line states, bus opcodes, snoop FSM encoding.
// Also used by the CPU-side controller, so the encodings must stay stable.
package sm_bus_snoop_pkg;

    localparam logic [1:0] INVALID  = 2'b00;
    localparam logic [1:0] SHARED   = 2'b01;
    localparam logic [1:0] MODIFIED = 2'b10;

    localparam logic [1:0] OP_NONE   = 2'b00;
    localparam logic [1:0] OP_RDMISS = 2'b01;
    localparam logic [1:0] OP_WRMISS = 2'b10;
    localparam logic [1:0] OP_INV    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_LOOKUP = 2'b01,
        S_WB     = 2'b10
    } snoop_fsm_t;

    // State a hit line moves to when another core's message is observed.
    // An invalidate seen on a Modified line is a protocol error and is
    // handled exactly like a writeMiss (line dropped after write-back).
    function automatic logic [1:0] snoop_next_state(input logic [1:0] cur,
                                                    input logic [1:0] op);
        logic [1:0] nxt;
        nxt = cur;
        case (op)
            OP_RDMISS: nxt = (cur == MODIFIED) ? SHARED : cur;
            OP_WRMISS: nxt = INVALID;
            OP_INV:    nxt = INVALID;
            default:   nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sm_bus_snoop_line_table.sv
// Direct-mapped tag/state table: two async read ports, a snoop state write and a CPU entry write.
// The snoop write wins when both target the same index in the same cycle.
module line_table
    import sm_bus_snoop_pkg::*;
#(
    parameter int NUM_LINES = 4,
    parameter int IDX_W     = 2,
    parameter int TAG_W     = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_a_index,
    output logic [TAG_W-1:0] rd_a_tag,
    output logic [1:0]       rd_a_state,
    input  logic [IDX_W-1:0] rd_b_index,
    output logic [1:0]       rd_b_state,
    input  logic             snp_we,
    input  logic [IDX_W-1:0] snp_index,
    input  logic [1:0]       snp_state,
    input  logic             cpu_we,
    input  logic [IDX_W-1:0] cpu_index,
    input  logic [TAG_W-1:0] cpu_tag,
    input  logic [1:0]       cpu_state
);

    logic [TAG_W-1:0] tag_mem   [NUM_LINES];
    logic [1:0]       state_mem [NUM_LINES];

    logic cpu_blocked;
    assign cpu_blocked = snp_we && (snp_index == cpu_index);

    assign rd_a_tag   = tag_mem[rd_a_index];
    assign rd_a_state = state_mem[rd_a_index];
    assign rd_b_state = state_mem[rd_b_index];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                tag_mem[i]   <= '0;
                state_mem[i] <= INVALID;
            end
        end else begin
            if (cpu_we && !cpu_blocked) begin
                tag_mem[cpu_index]   <= cpu_tag;
                state_mem[cpu_index] <= cpu_state;
            end
            if (snp_we) begin
                state_mem[snp_index] <= snp_state;
            end
        end
    end

endmodule

// File: rtl/sm_bus_snoop.sv
// Bus-side MSI snoop controller: looks up other cores' misses, demotes/invalidates hit lines,
// and on a Modified hit aborts the memory response and runs a write-back handshake.
module sm_bus_snoop
    import sm_bus_snoop_pkg::*;
#(
    parameter int NUM_LINES = 4,
    parameter int IDX_W     = 2,
    parameter int TAG_W     = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             snoop_valid,
    output logic             snoop_ready,
    input  logic [1:0]       snoop_op,
    input  logic [IDX_W-1:0] snoop_index,
    input  logic [TAG_W-1:0] snoop_tag,
    input  logic             cpu_upd_valid,
    output logic             cpu_upd_ready,
    input  logic [IDX_W-1:0] cpu_upd_index,
    input  logic [TAG_W-1:0] cpu_upd_tag,
    input  logic [1:0]       cpu_upd_state,
    output logic [1:0]       line_state,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [IDX_W-1:0] wb_index,
    output logic [TAG_W-1:0] wb_tag,
    output logic             abort_mem,
    output logic             snoop_done
);

    snoop_fsm_t       fsm;
    logic [1:0]       op_q;
    logic [IDX_W-1:0] index_q;
    logic [TAG_W-1:0] tag_q;

    logic [TAG_W-1:0] ent_tag;
    logic [1:0]       ent_state;
    logic [1:0]       next_state;
    logic             hit;
    logic             lookup_act;
    logic             need_wb;
    logic             snp_we;
    logic             cpu_we;

    assign hit        = (ent_state != INVALID) && (ent_tag == tag_q);
    assign lookup_act = (fsm == S_LOOKUP) && hit && (op_q != OP_NONE);
    assign next_state = snoop_next_state(ent_state, op_q);
    assign need_wb    = lookup_act && (ent_state == MODIFIED);
    assign snp_we     = lookup_act && (next_state != ent_state);

    // The entry under snoop is frozen for the CPU until the message retires.
    assign cpu_upd_ready = !((fsm != S_IDLE) && (cpu_upd_index == index_q));
    assign cpu_we        = cpu_upd_valid && cpu_upd_ready && (cpu_upd_state != 2'b11);
    assign snoop_ready   = (fsm == S_IDLE);

    line_table #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_table (
        .clock      (clock),
        .reset      (reset),
        .rd_a_index (index_q),
        .rd_a_tag   (ent_tag),
        .rd_a_state (ent_state),
        .rd_b_index (cpu_upd_index),
        .rd_b_state (line_state),
        .snp_we     (snp_we),
        .snp_index  (index_q),
        .snp_state  (next_state),
        .cpu_we     (cpu_we),
        .cpu_index  (cpu_upd_index),
        .cpu_tag    (cpu_upd_tag),
        .cpu_state  (cpu_upd_state)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm        <= S_IDLE;
            op_q       <= OP_NONE;
            index_q    <= '0;
            tag_q      <= '0;
            wb_valid   <= 1'b0;
            wb_index   <= '0;
            wb_tag     <= '0;
            abort_mem  <= 1'b0;
            snoop_done <= 1'b0;
        end else begin
            abort_mem  <= 1'b0;
            snoop_done <= 1'b0;
            case (fsm)
                S_IDLE: begin
                    if (snoop_valid) begin
                        op_q    <= snoop_op;
                        index_q <= snoop_index;
                        tag_q   <= snoop_tag;
                        fsm     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (need_wb) begin
                        abort_mem <= 1'b1;
                        wb_valid  <= 1'b1;
                        wb_index  <= index_q;
                        wb_tag    <= tag_q;
                        fsm       <= S_WB;
                    end else begin
                        snoop_done <= 1'b1;
                        fsm        <= S_IDLE;
                    end
                end
                S_WB: begin
                    if (wb_ready) begin
                        wb_valid   <= 1'b0;
                        snoop_done <= 1'b1;
                        fsm        <= S_IDLE;
                    end
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sm_bus_snoop.sv
// Cycle-by-cycle vector bench for sm_bus_snoop plus a bounded latency sequence.
module tb_sm_bus_snoop;

    logic       clock = 1'b0;
    logic       reset;
    logic       snoop_valid, snoop_ready;
    logic [1:0] snoop_op, snoop_index;
    logic [7:0] snoop_tag;
    logic       cpu_upd_valid, cpu_upd_ready;
    logic [1:0] cpu_upd_index, cpu_upd_state;
    logic [7:0] cpu_upd_tag;
    logic [1:0] line_state;
    logic       wb_valid, wb_ready;
    logic [1:0] wb_index;
    logic [7:0] wb_tag;
    logic       abort_mem, snoop_done;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    sm_bus_snoop dut (
        .clock         (clock),
        .reset         (reset),
        .snoop_valid   (snoop_valid),
        .snoop_ready   (snoop_ready),
        .snoop_op      (snoop_op),
        .snoop_index   (snoop_index),
        .snoop_tag     (snoop_tag),
        .cpu_upd_valid (cpu_upd_valid),
        .cpu_upd_ready (cpu_upd_ready),
        .cpu_upd_index (cpu_upd_index),
        .cpu_upd_tag   (cpu_upd_tag),
        .cpu_upd_state (cpu_upd_state),
        .line_state    (line_state),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_index      (wb_index),
        .wb_tag        (wb_tag),
        .abort_mem     (abort_mem),
        .snoop_done    (snoop_done)
    );

    typedef struct {
        bit       rst;
        bit       sv;
        bit [1:0] sop, sidx;
        bit [7:0] stag;
        bit       cv;
        bit [1:0] cidx;
        bit [7:0] ctag;
        bit [1:0] cst;
        bit       wbr;
        bit       e_sr, e_cr;
        bit [1:0] e_ls;
        bit       e_wv;
        bit [1:0] e_widx;
        bit [7:0] e_wtag;
        bit       e_ab, e_dn;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, bit sv, bit [1:0] sop, bit [1:0] sidx, bit [7:0] stag,
                                bit cv, bit [1:0] cidx, bit [7:0] ctag, bit [1:0] cst, bit wbr,
                                bit sr, bit cr, bit [1:0] ls, bit wv, bit [1:0] widx,
                                bit [7:0] wtag, bit ab, bit dn);
        vec_t v;
        v.rst = rst; v.sv = sv; v.sop = sop; v.sidx = sidx; v.stag = stag;
        v.cv = cv; v.cidx = cidx; v.ctag = ctag; v.cst = cst; v.wbr = wbr;
        v.e_sr = sr; v.e_cr = cr; v.e_ls = ls; v.e_wv = wv; v.e_widx = widx;
        v.e_wtag = wtag; v.e_ab = ab; v.e_dn = dn;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=0x%0h expected=0x%0h", name, idx, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset         = v.rst;
        snoop_valid   = v.sv;
        snoop_op      = v.sop;
        snoop_index   = v.sidx;
        snoop_tag     = v.stag;
        cpu_upd_valid = v.cv;
        cpu_upd_index = v.cidx;
        cpu_upd_tag   = v.ctag;
        cpu_upd_state = v.cst;
        wb_ready      = v.wbr;
    endtask

    initial begin
        //          rst sv op ix tag    cv ix tag    st wbr  sr cr ls wv wix wtag  ab dn
        // 1: Modified line hit by readMiss, write-back with wb_ready high
        vecs.push_back(mk(0,0,0,0,8'h00, 0,1,8'h00,0, 0, 1,1,0, 0,0,8'h00, 0,0));
        vecs.push_back(mk(0,0,0,0,8'h00, 1,1,8'h3A,2, 0, 1,1,0, 0,0,8'h00, 0,0));
        vecs.push_back(mk(0,1,1,1,8'h3A, 0,1,8'h00,0, 0, 1,1,2, 0,0,8'h00, 0,0));
        vecs.push_back(mk(0,0,0,0,8'h00, 0,1,8'h00,0, 0, 0,0,2, 0,0,8'h00, 0,0));
        vecs.push_back(mk(0,0,0,0,8'h00, 0,1,8'h00,0, 1, 0,0,1, 1,1,8'h3A, 1,0));
        vecs.push_back(mk(0,0,0,0,8'h00, 0,1,8'h00,0, 1, 1,1,1, 0,0,8'h00, 0,1));
        vecs.push_back(mk(0,0,0,0,8'h00, 0,1,8'h00,0, 0, 1,1,1, 0,0,8'h00, 0,0));
        // 2: Shared line invalidated
        vecs.push_back(mk(0,0,0,0,8'h00, 1,2,8'h10,1, 0, 1,1,0, 0,0,8'h00, 0,0));
        vecs.push_back(mk(0,1,3,2,8'h10, 0,2,8'h00,0, 0, 1,1,1, 0,0,8'h00, 0,0));
        vecs.push_back(mk(0,0,0,0,8'h00, 0,2,8'h00,0, 0, 0,0,1, 0,0,8'h00, 0,0));
        vecs.push_back(mk(0,0,0,0,8'h00, 0,2,8'h00,0, 0, 1,1,0, 0,0,8'h00, 0,1));
        // 3: tag mismatch leaves Modified line alone
        vecs.push_back(mk(0,0,0,0,8'h00, 1,0,8'h05,2, 0, 1,1,0, 0,0,8'h00, 0,0));
        vecs.push_back(mk(0,1,2,0,8'h06, 0,0,8'h00,0, 0, 1,1,2, 0,0,8'h00, 0,0));
        vecs.push_back(mk(0,0,0,0,8'h00, 0,0,8'h00,0, 0, 0,0,2, 0,0,8'h00, 0,0));
        vecs.push_back(mk(0,0,0,0,8'h00, 0,0,8'h00,0, 0, 1,1,2, 0,0,8'h00, 0,1));
        // 4: writeMiss hit on Modified, wb_ready low 4 cycles; idx3 stalled, idx0 accepted
        vecs.push_back(mk(0,0,0,0,8'h00, 1,3,8'h77,2, 0, 1,1,0, 0,0,8'h00, 0,0));
        vecs.push_back(mk(0,1,2,3,8'h77, 0,3,8'h00,0, 0, 1,1,2, 0,0,8'h00, 0,0));
        vecs.push_back(mk(0,0,0,0,8'h00, 1,3,8'h11,1, 0, 0,0,2, 0,0,8'h00, 0,0));
        vecs.push_back(mk(0,0,0,0,8'h00, 1,3,8'h11,1, 0, 0,0,0, 1,3,8'h77, 1,0));
        vecs.push_back(mk(0,0,0,0,8'h00, 1,3,8'h11,1, 0, 0,0,0, 1,3,8'h77, 0,0));
        vecs.push_back(mk(0,0,0,0,8'h00, 1,3,8'h11,1, 0, 0,0,0, 1,3,8'h77, 0,0));
        vecs.push_back(mk(0,0,0,0,8'h00, 1,0,8'h44,1, 0, 0,1,2, 1,3,8'h77, 0,0));
        vecs.push_back(mk(0,0,0,0,8'h00, 0,0,8'h00,0, 1, 0,1,1, 1,3,8'h77, 0,0));
        vecs.push_back(mk(0,0,0,0,8'h00, 0,3,8'h00,0, 0, 1,1,0, 0,0,8'h00, 0,1));
        // 5: same-cycle CPU update and snoop accept on idx1
        vecs.push_back(mk(0,1,1,1,8'h22, 1,1,8'h22,2, 0, 1,1,1, 0,0,8'h00, 0,0));
        vecs.push_back(mk(0,0,0,0,8'h00, 0,1,8'h00,0, 0, 0,0,2, 0,0,8'h00, 0,0));
        vecs.push_back(mk(0,0,0,0,8'h00, 0,1,8'h00,0, 1, 0,0,1, 1,1,8'h22, 1,0));
        vecs.push_back(mk(0,0,0,0,8'h00, 0,1,8'h00,0, 0, 1,1,1, 0,0,8'h00, 0,1));
        // op 00 on a hit line: accepted, no effect
        vecs.push_back(mk(0,1,0,1,8'h22, 0,1,8'h00,0, 0, 1,1,1, 0,0,8'h00, 0,0));
        vecs.push_back(mk(0,0,0,0,8'h00, 0,1,8'h00,0, 0, 0,0,1, 0,0,8'h00, 0,0));
        vecs.push_back(mk(0,0,0,0,8'h00, 0,1,8'h00,0, 0, 1,1,1, 0,0,8'h00, 0,1));
        // 6: invalidate on Modified (treated as writeMiss), reset during WB wait
        vecs.push_back(mk(0,0,0,0,8'h00, 1,2,8'h5C,2, 0, 1,1,0, 0,0,8'h00, 0,0));
        vecs.push_back(mk(0,1,3,2,8'h5C, 0,2,8'h00,0, 0, 1,1,2, 0,0,8'h00, 0,0));
        vecs.push_back(mk(0,0,0,0,8'h00, 0,2,8'h00,0, 0, 0,0,2, 0,0,8'h00, 0,0));
        vecs.push_back(mk(0,0,0,0,8'h00, 0,2,8'h00,0, 0, 0,0,0, 1,2,8'h5C, 1,0));
        vecs.push_back(mk(1,0,0,0,8'h00, 0,2,8'h00,0, 0, 0,0,0, 1,2,8'h5C, 0,0));
        vecs.push_back(mk(0,0,0,0,8'h00, 0,0,8'h00,0, 0, 1,1,0, 0,0,8'h00, 0,0));
        vecs.push_back(mk(0,0,0,0,8'h00, 0,1,8'h00,0, 0, 1,1,0, 0,0,8'h00, 0,0));
        vecs.push_back(mk(0,0,0,0,8'h00, 0,2,8'h00,0, 0, 1,1,0, 0,0,8'h00, 0,0));
        vecs.push_back(mk(0,0,0,0,8'h00, 0,3,8'h00,0, 0, 1,1,0, 0,0,8'h00, 0,0));

        drive(mk(1,0,0,0,8'h00, 0,0,8'h00,0, 0, 0,0,0, 0,0,8'h00, 0,0));
        repeat (2) @(posedge clock);

        foreach (vecs[i]) begin
            @(negedge clock);
            drive(vecs[i]);
            #1;
            chk("snoop_ready",   i, {7'd0, snoop_ready},   {7'd0, vecs[i].e_sr});
            chk("cpu_upd_ready", i, {7'd0, cpu_upd_ready}, {7'd0, vecs[i].e_cr});
            chk("line_state",    i, {6'd0, line_state},    {6'd0, vecs[i].e_ls});
            chk("wb_valid",      i, {7'd0, wb_valid},      {7'd0, vecs[i].e_wv});
            chk("abort_mem",     i, {7'd0, abort_mem},     {7'd0, vecs[i].e_ab});
            chk("snoop_done",    i, {7'd0, snoop_done},    {7'd0, vecs[i].e_dn});
            if (vecs[i].e_wv) begin
                chk("wb_index", i, {6'd0, wb_index}, {6'd0, vecs[i].e_widx});
                chk("wb_tag",   i, wb_tag,           vecs[i].e_wtag);
            end
        end

        // Bounded latency sequence: Modified readMiss with wb_ready high completes on edge 3.
        begin
            int  lat;
            bit  seen_wb;
            lat     = 0;
            seen_wb = 1'b0;
            @(negedge clock);
            drive(mk(0,0,0,0,8'h00, 1,0,8'h99,2, 1, 0,0,0, 0,0,8'h00, 0,0));
            @(negedge clock);
            drive(mk(0,1,1,0,8'h99, 0,0,8'h00,0, 1, 0,0,0, 0,0,8'h00, 0,0));
            for (int n = 1; n <= 10; n++) begin
                @(negedge clock);
                snoop_valid = 1'b0;
                #1;
                if (wb_valid && wb_tag == 8'h99) seen_wb = 1'b1;
                if (snoop_done) begin
                    lat = n;
                    break;
                end
            end
            checks++;
            if (lat == 0) begin
                failures++;
                $display("FAIL latency_timeout got=none expected=3");
            end else begin
                chk("wb_latency", 0, 8'(lat), 8'd3);
            end
            chk("wb_seen",        0, {7'd0, seen_wb},    8'd1);
            chk("final_state",    0, {6'd0, line_state}, 8'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
